// File: rtl/expand_key_ctrl.sv
// expand_key_ctrl: sequences the 521 chained Blowfish encryptions of bcrypt ExpandKey
// and writes each result half back into the P-array and S-boxes over SRAM port A.
module expand_key_ctrl #(
  parameter int P_ARRAY_OFFSET = 4000,
  parameter int S_BOX_OFFSET = 0,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              salt_en,
  input  logic [127:0]      salt,
  output logic              busy,
  output logic              done,
  output logic              f_start,
  output logic [31:0]       f_L,
  output logic [31:0]       f_R,
  input  logic [31:0]       f_resultL,
  input  logic [31:0]       f_resultR,
  input  logic              f_done,
  input  logic [ADDR_W-1:0] f_addr_a,
  input  logic              f_cs_a_l,
  input  logic              f_we_a_l,
  input  logic              f_oe_a_l,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [31:0]       sram_data_in_a,
  output logic              sram_cs_a_l,
  output logic              sram_we_a_l,
  output logic              sram_oe_a_l
);
  typedef enum logic [2:0] {IDLE, PREP, LAUNCH, WAIT_F, WR_L, WR_R, DONE} state_t;
  state_t state, state_nx;
  logic [10:0] k;
  logic n, salt_on, wr;
  logic [31:0] l_reg, r_reg, wdata;
  logic [63:0] half;
  function automatic logic [ADDR_W-1:0] addr_of(input logic [10:0] i);
    addr_of = i < 11'd18 ? ADDR_W'(P_ARRAY_OFFSET + int'(i)) : ADDR_W'(S_BOX_OFFSET + int'(i) - 18);
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? PREP : IDLE;
      PREP:    state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT_F;
      WAIT_F:  state_nx = f_done ? WR_L : WAIT_F;
      WR_L:    state_nx = WR_R;
      WR_R:    state_nx = k == 11'd1040 ? DONE : PREP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // even encryptions salt with the upper 64 bits, odd ones with the lower 64
  assign half = n ? salt[63:0] : salt[127:64];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= '0;
      n <= 1'b0;
      salt_on <= 1'b0;
      l_reg <= '0;
      r_reg <= '0;
      f_L <= '0;
      f_R <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k <= '0;
          n <= 1'b0;
          salt_on <= salt_en;
          l_reg <= '0;
          r_reg <= '0;
        end
        PREP: begin
          f_L <= salt_on ? l_reg ^ half[63:32] : l_reg;
          f_R <= salt_on ? r_reg ^ half[31:0] : r_reg;
        end
        WAIT_F: if (f_done) begin
          l_reg <= f_resultL;
          r_reg <= f_resultR;
        end
        WR_R: begin
          k <= k + 11'd2;
          n <= ~n;
        end
        default: ;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign f_start = state == LAUNCH;
  assign wr = state == WR_L || state == WR_R;
  assign wdata = state == WR_R ? r_reg : l_reg;
  assign sram_addr_a = reset ? '0 : wr ? addr_of(state == WR_R ? k + 11'd1 : k) : f_addr_a;
  assign sram_data_in_a = wr ? wdata : '0;
  assign sram_cs_a_l = reset | (!wr & f_cs_a_l);
  assign sram_we_a_l = reset | (!wr & f_we_a_l);
  assign sram_oe_a_l = reset | wr | f_oe_a_l;
endmodule

// File: tb/tb_expand_key_ctrl.sv
// tb_expand_key_ctrl: randomized full-run checks against a behavioural ExpandKey model,
// plus directed arbitration, ignore and reset-abort sequences.
module tb_expand_key_ctrl;
  logic clk = 1'b0;
  logic reset, start, salt_en, f_done, f_cs_a_l, f_we_a_l, f_oe_a_l;
  logic [127:0] salt;
  logic busy, done, f_start, sram_cs_a_l, sram_we_a_l, sram_oe_a_l;
  logic [31:0] f_L, f_R, f_resultL, f_resultR, sram_data_in_a;
  logic [11:0] f_addr_a, sram_addr_a;
  int n_cmp = 0, n_err = 0;
  logic [31:0] launch_l_q[$], launch_r_q[$], wr_addr_q[$], wr_data_q[$];
  logic [31:0] exp_l_q[$], exp_r_q[$], exp_addr_q[$], exp_data_q[$];
  int done_cnt = 0;
  bit auto_f = 0;
  int mode = 0, lat = 3;
  always #5 clk = ~clk;

  expand_key_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .salt_en(salt_en), .salt(salt),
    .busy(busy), .done(done), .f_start(f_start), .f_L(f_L), .f_R(f_R),
    .f_resultL(f_resultL), .f_resultR(f_resultR), .f_done(f_done),
    .f_addr_a(f_addr_a), .f_cs_a_l(f_cs_a_l), .f_we_a_l(f_we_a_l), .f_oe_a_l(f_oe_a_l),
    .sram_addr_a(sram_addr_a), .sram_data_in_a(sram_data_in_a),
    .sram_cs_a_l(sram_cs_a_l), .sram_we_a_l(sram_we_a_l), .sram_oe_a_l(sram_oe_a_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] feistel(input int m, input logic [31:0] l, input logic [31:0] r);
    if (m == 0) return {l + 32'd1, r + 32'd2};
    if (m == 1) return {l, r};
    return {(l * 32'h9e3779b1) ^ r, ({r[24:0], r[31:25]} + l) ^ 32'hdeadbeef};
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return q.size() > i ? q[i] : 32'hxxxxxxxx;
  endfunction

  // stand-in feistel engine and bus monitor, sampled mid-cycle
  initial begin
    bit pending = 0;
    int cnt = 0;
    logic [63:0] res = '0;
    forever begin
      @(posedge clk);
      #2;
      if (f_start) begin
        launch_l_q.push_back(f_L);
        launch_r_q.push_back(f_R);
      end
      if (!sram_cs_a_l && !sram_we_a_l) begin
        wr_addr_q.push_back(32'(sram_addr_a));
        wr_data_q.push_back(sram_data_in_a);
      end
      if (done) done_cnt++;
      if (reset) begin
        pending = 0;
        if (auto_f) f_done = 0;
      end else if (auto_f) begin
        f_done = 0;
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            {f_resultL, f_resultR} = res;
            f_done = 1;
            pending = 0;
          end
        end
        if (f_start) begin
          pending = 1;
          cnt = lat;
          res = feistel(mode, f_L, f_R);
        end
      end
    end
  end

  task automatic build_model(input bit se, input logic [127:0] s, input int m);
    logic [31:0] l = 0, r = 0, fl, fr;
    logic [63:0] h, o;
    exp_l_q.delete(); exp_r_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    for (int e = 0; e < 521; e++) begin
      h = (e % 2 == 1) ? s[63:0] : s[127:64];
      fl = se ? l ^ h[63:32] : l;
      fr = se ? r ^ h[31:0] : r;
      exp_l_q.push_back(fl);
      exp_r_q.push_back(fr);
      o = feistel(m, fl, fr);
      l = o[63:32];
      r = o[31:0];
      for (int j = 2 * e; j < 2 * e + 2; j++)
        exp_addr_q.push_back(j < 18 ? (4000 + j) % 4096 : (j - 18) % 4096);
      exp_data_q.push_back(l);
      exp_data_q.push_back(r);
    end
  endtask

  task automatic run_full(input bit se, input logic [127:0] s, input int m, input int l);
    bit seen = 0;
    build_model(se, s, m);
    launch_l_q.delete(); launch_r_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0;
    salt_en = se; salt = s; mode = m; lat = l; auto_f = 1;
    start = 1;
    tick();
    start = 0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 20000 && !seen; i++) begin
      tick();
      start = (i == 40);
      if (done) seen = 1;
    end
    start = 0;
    check("done_seen", seen, 1);
    tick();
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    tick();
    check("done_count", done_cnt, 1);
    check("n_launch", launch_l_q.size(), 521);
    check("n_write", wr_addr_q.size(), 1042);
    for (int e = 0; e < 521; e++) begin
      check($sformatf("f_L[%0d]", e), at(launch_l_q, e), exp_l_q[e]);
      check($sformatf("f_R[%0d]", e), at(launch_r_q, e), exp_r_q[e]);
    end
    for (int j = 0; j < 1042; j++) begin
      check($sformatf("wr_addr[%0d]", j), at(wr_addr_q, j), exp_addr_q[j]);
      check($sformatf("wr_data[%0d]", j), at(wr_data_q, j), exp_data_q[j]);
    end
  endtask

  initial begin
    reset = 1; start = 0; salt_en = 0; salt = '0; f_done = 0;
    f_resultL = '0; f_resultR = '0; f_addr_a = 12'habc;
    f_cs_a_l = 1; f_we_a_l = 1; f_oe_a_l = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fstart", f_start, 0);
    check("rst_cs", sram_cs_a_l, 1);
    check("rst_we", sram_we_a_l, 1);
    check("rst_oe", sram_oe_a_l, 1);
    check("rst_addr", sram_addr_a, 0);
    repeat (3) tick();
    reset = 0;
    tick();
    check("idle_pass_addr", sram_addr_a, 12'habc);
    f_addr_a = 0;
    // f_done while idle must be ignored
    f_done = 1;
    tick();
    f_done = 0;
    tick();
    check("idle_fdone_busy", busy, 0);
    check("idle_fdone_writes", wr_addr_q.size(), 0);
    check("idle_fdone_launch", launch_l_q.size(), 0);
    // directed arbitration with a hand-driven feistel
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 10 && !f_start; i++) tick();
    check("man_fstart", f_start, 1);
    check("man_fL0", f_L, 0);
    check("man_fR0", f_R, 0);
    tick();
    f_addr_a = 12'h123; f_cs_a_l = 0; f_oe_a_l = 0;
    #1;
    check("arb_addr", sram_addr_a, 12'h123);
    check("arb_cs", sram_cs_a_l, 0);
    check("arb_oe", sram_oe_a_l, 0);
    check("arb_we", sram_we_a_l, 1);
    start = 1;
    tick();
    start = 0;
    check("busy_start_ignored", busy, 1);
    check("fstart_start_ignored", f_start, 0);
    f_resultL = 32'ha5a50001; f_resultR = 32'h5a5a0002; f_done = 1;
    tick();
    f_done = 0;
    check("wrl_addr", sram_addr_a, 12'd4000);
    check("wrl_data", sram_data_in_a, 32'ha5a50001);
    check("wrl_cs", sram_cs_a_l, 0);
    check("wrl_we", sram_we_a_l, 0);
    check("wrl_oe", sram_oe_a_l, 1);
    tick();
    check("wrr_addr", sram_addr_a, 12'd4001);
    check("wrr_data", sram_data_in_a, 32'h5a5a0002);
    tick();
    check("prep_pass_addr", sram_addr_a, 12'h123);
    check("prep_pass_we", sram_we_a_l, 1);
    tick();
    check("man_fstart2", f_start, 1);
    check("man_fL1", f_L, 32'ha5a50001);
    check("man_fR1", f_R, 32'h5a5a0002);
    tick();
    check("man_writes", wr_addr_q.size(), 2);
    // abort in WAIT_F with reset asserted mid-cycle
    #2;
    reset = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_cs", sram_cs_a_l, 1);
    check("abort_we", sram_we_a_l, 1);
    check("abort_oe", sram_oe_a_l, 1);
    check("abort_addr", sram_addr_a, 0);
    check("abort_fstart", f_start, 0);
    f_addr_a = 0; f_cs_a_l = 1; f_oe_a_l = 1;
    tick();
    reset = 0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_cs", sram_cs_a_l, 1);
    check("post_rst_writes", wr_addr_q.size(), 2);
    // restart from zero, feistel = (L+1, R+2), latency 3
    run_full(0, '0, 0, 3);
    check("w0_addr", at(wr_addr_q, 0), 4000);
    check("w0_data", at(wr_data_q, 0), 1);
    check("w1_addr", at(wr_addr_q, 1), 4001);
    check("w1_data", at(wr_data_q, 1), 2);
    check("w2_addr", at(wr_addr_q, 2), 4002);
    check("w2_data", at(wr_data_q, 2), 2);
    check("w3_addr", at(wr_addr_q, 3), 4003);
    check("w3_data", at(wr_data_q, 3), 4);
    check("l1_fL", at(launch_l_q, 1), 1);
    check("l1_fR", at(launch_r_q, 1), 2);
    check("w18_addr", at(wr_addr_q, 18), 0);
    check("wlast0_addr", at(wr_addr_q, 1040), 1022);
    check("wlast1_addr", at(wr_addr_q, 1041), 1023);
    // salted run with identity feistel
    run_full(1, 128'h00000001_00000002_00000003_00000004, 1, 2);
    check("salt_l0", at(launch_l_q, 0), 1);
    check("salt_r0", at(launch_r_q, 0), 2);
    check("salt_l1", at(launch_l_q, 1), 2);
    check("salt_r1", at(launch_r_q, 1), 6);
    check("salt_l2", at(launch_l_q, 2), 3);
    check("salt_r2", at(launch_r_q, 2), 4);
    for (int t = 0; t < 2; t++)
      run_full(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 2,
               int'($urandom_range(1, 6)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
